// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the execute-side redirect logic
package riscv_pkg;

  localparam int TAG_W_DEF = 4;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } redir_state_t;

  localparam logic [31:0] NO_REDIRECT = 32'h0;

endpackage

// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - tag check, wrong-path kill and NewPC redirect pulse
// Tag advances only on an issued redirect so it tracks fetch's nonzero-NewPC counter.
module branch_redirect
  import riscv_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int START_TAG = 0,
  parameter int KCNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              is_cti,
  input  logic              taken,
  input  logic [31:0]       target,
  input  logic              hold,
  output logic [31:0]       NewPC,
  output logic              commit,
  output logic              kill,
  output logic [TAG_W-1:0]  tag_cur,
  output logic              bad_target,
  output logic [KCNT_W-1:0] kill_cnt
);

  redir_state_t state, state_next;

  logic acc;
  logic match;
  logic redir;
  logic commit_d;
  logic kill_d;
  logic bad_d;
  logic [31:0] new_pc_d;

  assign acc   = valid_in & ~hold;
  assign match = (tag_in == tag_cur);
  assign redir = acc & match & is_cti & taken & (target != NO_REDIRECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (redir) state_next = FLUSH;
      end
      FLUSH: begin
        // Stale-tag instructions keep us here; the first correct-path one releases.
        if (redir) state_next = FLUSH;
        else if (acc & match) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    commit_d = acc & match;
    kill_d   = acc & ~match;
    bad_d    = acc & match & is_cti & taken & (target == NO_REDIRECT);
    new_pc_d = redir ? target : NO_REDIRECT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      NewPC      <= NO_REDIRECT;
      commit     <= 1'b0;
      kill       <= 1'b0;
      bad_target <= 1'b0;
      tag_cur    <= TAG_W'(START_TAG);
      kill_cnt   <= '0;
    end else begin
      NewPC      <= new_pc_d;
      commit     <= commit_d;
      kill       <= kill_d;
      bad_target <= bad_d;
      if (redir) begin
        tag_cur <= tag_cur + 1'b1;
      end
      if (kill_d && (kill_cnt != {KCNT_W{1'b1}})) begin
        kill_cnt <= kill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
// tb/tb_branch_redirect.sv - vector table, corner sequences and random model check
module tb_branch_redirect;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  tag_in;
  logic        is_cti;
  logic        taken;
  logic [31:0] target;
  logic        hold;
  logic [31:0] NewPC;
  logic        commit;
  logic        kill;
  logic [3:0]  tag_cur;
  logic        bad_target;
  logic [7:0]  kill_cnt;

  int total = 0;
  int bad = 0;

  branch_redirect #(.TAG_W(4), .START_TAG(0), .KCNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .tag_in(tag_in),
    .is_cti(is_cti), .taken(taken), .target(target), .hold(hold),
    .NewPC(NewPC), .commit(commit), .kill(kill), .tag_cur(tag_cur),
    .bad_target(bad_target), .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  tg;
    logic        cti;
    logic        tk;
    logic [31:0] tgt;
    logic        h;
    logic [31:0] e_pc;
    logic        e_c;
    logic        e_k;
    logic [3:0]  e_tag;
    logic        e_bad;
    logic [7:0]  e_kc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] tg, input logic cti,
                       input logic tk, input logic [31:0] tgt, input logic h);
    valid_in = v; tag_in = tg; is_cti = cti; taken = tk; target = tgt; hold = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [31:0] pc, input logic c, input logic k,
                         input logic [3:0] tg, input logic b, input logic [7:0] kc);
    chk({nm, ".NewPC"}, NewPC, pc);
    chk({nm, ".commit"}, {31'd0, commit}, {31'd0, c});
    chk({nm, ".kill"}, {31'd0, kill}, {31'd0, k});
    chk({nm, ".tag_cur"}, {28'd0, tag_cur}, {28'd0, tg});
    chk({nm, ".bad_target"}, {31'd0, bad_target}, {31'd0, b});
    chk({nm, ".kill_cnt"}, {24'd0, kill_cnt}, {24'd0, kc});
  endtask

  // Reference model: tag/counter bookkeeping straight from the protocol rules.
  int          m_tag;
  int          m_kc;
  logic [31:0] e_pc;
  logic        e_c, e_k, e_b;

  task automatic model_step(input logic rst, input logic v, input logic [3:0] tg,
                            input logic cti, input logic tk, input logic [31:0] tgt,
                            input logic h);
    bit accepted, matched;
    if (rst) begin
      m_tag = 0; m_kc = 0; e_pc = 0; e_c = 0; e_k = 0; e_b = 0;
      return;
    end
    accepted = v && !h;
    matched  = (int'(tg) == m_tag);
    e_c  = accepted && matched;
    e_k  = accepted && !matched;
    e_b  = e_c && cti && tk && (tgt == 0);
    e_pc = (e_c && cti && tk && tgt != 0) ? tgt : 32'h0;
    if (e_pc != 0) m_tag = (m_tag + 1) % 16;
    if (e_k && m_kc < 255) m_kc = m_kc + 1;
  endtask

  initial begin
    // Sequence from a fresh reset: jump, drain, hold, zero target, back-to-back.
    vecs[0]  = '{1'b1, 4'd0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100, 1'b1, 1'b0, 4'd1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 4'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 4'd1, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 4'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 4'd1, 1'b0, 8'd2};
    vecs[3]  = '{1'b1, 4'd0, 1'b1, 1'b1, 32'h44,  1'b0, 32'h0,   1'b0, 1'b1, 4'd1, 1'b0, 8'd3};
    vecs[4]  = '{1'b1, 4'd1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 4'd1, 1'b0, 8'd3};
    vecs[5]  = '{1'b1, 4'd1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h0,   1'b0, 1'b0, 4'd1, 1'b0, 8'd3};
    vecs[6]  = '{1'b1, 4'd1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h200, 1'b1, 1'b0, 4'd2, 1'b0, 8'd3};
    vecs[7]  = '{1'b1, 4'd2, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 4'd2, 1'b1, 8'd3};
    vecs[8]  = '{1'b0, 4'd2, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0,   1'b0, 1'b0, 4'd2, 1'b0, 8'd3};
    vecs[9]  = '{1'b1, 4'd2, 1'b1, 1'b0, 32'h300, 1'b0, 32'h0,   1'b1, 1'b0, 4'd2, 1'b0, 8'd3};
    vecs[10] = '{1'b1, 4'd2, 1'b1, 1'b1, 32'h400, 1'b0, 32'h400, 1'b1, 1'b0, 4'd3, 1'b0, 8'd3};
    vecs[11] = '{1'b1, 4'd3, 1'b1, 1'b1, 32'h500, 1'b0, 32'h500, 1'b1, 1'b0, 4'd4, 1'b0, 8'd3};

    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].tg, vecs[i].cti, vecs[i].tk, vecs[i].tgt, vecs[i].h);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_c, vecs[i].e_k,
              vecs[i].e_tag, vecs[i].e_bad, vecs[i].e_kc);
    end

    // Walk the tag up to 15 and wrap it with a taken branch to 0x40.
    for (int t = 4; t < 15; t++) begin
      drive(1'b1, 4'(t), 1'b1, 1'b1, 32'h1000 + t, 1'b0);
      step();
      chk("walk.NewPC", NewPC, 32'h1000 + t);
    end
    drive(1'b1, 4'd15, 1'b1, 1'b1, 32'h40, 1'b0);
    step();
    chk_all("wrap", 32'h40, 1'b1, 1'b0, 4'd0, 1'b0, 8'd3);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("wrap_after", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd3);

    // Reset the cycle after a redirect, while another redirect is being offered.
    drive(1'b1, 4'd0, 1'b1, 1'b1, 32'h80, 1'b0);
    step();
    chk("pre_rst.NewPC", NewPC, 32'h80);
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h90, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("rst_mid", 32'h0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    drive(1'b1, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("after_rst", 32'h0, 1'b1, 1'b0, 4'd0, 1'b0, 8'd0);

    // Kill counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 4'd7, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end
    chk_all("sat", 32'h0, 1'b0, 1'b1, 4'd0, 1'b0, 8'd255);

    // Random traffic against the reference model.
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    step();
    model_step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst, r_v, r_cti, r_tk, r_h;
      logic [3:0]  r_tg;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 99) == 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_tg  = ($urandom_range(0, 1) == 0) ? 4'(m_tag) : 4'($urandom_range(0, 15));
      r_cti = $urandom_range(0, 1) == 1;
      r_tk  = $urandom_range(0, 1) == 1;
      r_tgt = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      r_h   = ($urandom_range(0, 4) == 0);
      reset = r_rst;
      drive(r_v, r_tg, r_cti, r_tk, r_tgt, r_h);
      model_step(r_rst, r_v, r_tg, r_cti, r_tk, r_tgt, r_h);
      step();
      chk_all("rand", e_pc, e_c, e_k, 4'(m_tag), e_b, 8'(m_kc));
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
